// File: rtl/output_unit.sv
// ---------------------------------------------------------------------------
// output_unit
// Output side of the basic computer's terminal I/O. An accepted OUT strobe
// captures AC[7:0] into OUTR, clears FGO and transmits the character as an
// asynchronous frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
// FGO returns to 1 when the stop bit completes.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   ac_outdata   : AC[7:0], character to send
//   outr_load    : OUT strobe from control
//   ien          : interrupt-enable flip-flop value
//   outr_outdata : OUTR register contents
//   fgo          : output flag, 1 = ready for a new character
//   irq          : fgo & ien (combinational)
//   tx           : serial line, idles high (registered)
// ---------------------------------------------------------------------------
module output_unit #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ac_outdata,
   input  logic       outr_load,
   input  logic       ien,
   output logic [7:0] outr_outdata,
   output logic       fgo,
   output logic       irq,
   output logic       tx
);

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [BAUD_W-1:0] baud_cnt_r, baud_cnt_s;
   logic [2:0]        bit_cnt_r, bit_cnt_s;
   logic [7:0]        outr_r, outr_s;
   logic              fgo_r, fgo_s;
   logic              tx_r, tx_s;
   logic              baud_last_s;
   logic [2:0]        bit_inc_s;
   logic [BAUD_W-1:0] baud_inc_s;

   assign baud_last_s = (baud_cnt_r == BAUD_LAST);
   assign baud_inc_s  = baud_cnt_r + {{(BAUD_W-1){1'b0}}, 1'b1};
   assign bit_inc_s   = bit_cnt_r + 3'd1;

   // Next-state and next-output decode for the transmit FSM. The line value
   // is computed one edge ahead so tx itself comes straight from a flop.
   always_comb begin
      state_s    = state_r;
      baud_cnt_s = baud_cnt_r;
      bit_cnt_s  = bit_cnt_r;
      outr_s     = outr_r;
      fgo_s      = fgo_r;
      tx_s       = tx_r;
      case (state_r)
         ST_IDLE: begin
            tx_s = 1'b1;
            if (outr_load && fgo_r) begin
               outr_s     = ac_outdata;
               fgo_s      = 1'b0;
               state_s    = ST_START;
               baud_cnt_s = {BAUD_W{1'b0}};
               tx_s       = 1'b0;
            end else begin
               baud_cnt_s = {BAUD_W{1'b0}};
            end
         end
         ST_START: begin
            if (baud_last_s) begin
               state_s    = ST_DATA;
               baud_cnt_s = {BAUD_W{1'b0}};
               bit_cnt_s  = 3'd0;
               tx_s       = outr_r[0];
            end else begin
               baud_cnt_s = baud_inc_s;
            end
         end
         ST_DATA: begin
            if (baud_last_s) begin
               baud_cnt_s = {BAUD_W{1'b0}};
               if (bit_cnt_r == 3'd7) begin
                  state_s = ST_STOP;
                  tx_s    = 1'b1;
               end else begin
                  bit_cnt_s = bit_inc_s;
                  tx_s      = outr_r[bit_inc_s];
               end
            end else begin
               baud_cnt_s = baud_inc_s;
            end
         end
         ST_STOP: begin
            tx_s = 1'b1;
            if (baud_last_s) begin
               state_s    = ST_IDLE;
               baud_cnt_s = {BAUD_W{1'b0}};
               fgo_s      = 1'b1;
            end else begin
               baud_cnt_s = baud_inc_s;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            baud_cnt_s = {BAUD_W{1'b0}};
            bit_cnt_s  = 3'd0;
            fgo_s      = 1'b1;
            tx_s       = 1'b1;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         baud_cnt_r <= {BAUD_W{1'b0}};
         bit_cnt_r  <= 3'd0;
         outr_r     <= 8'h00;
         fgo_r      <= 1'b1;
         tx_r       <= 1'b1;
      end else begin
         state_r    <= state_s;
         baud_cnt_r <= baud_cnt_s;
         bit_cnt_r  <= bit_cnt_s;
         outr_r     <= outr_s;
         fgo_r      <= fgo_s;
         tx_r       <= tx_s;
      end
   end

   assign outr_outdata = outr_r;
   assign fgo          = fgo_r;
   assign tx           = tx_r;
   assign irq          = fgo_r & ien;

endmodule
